ch_sweep_ctl: RTL and testbench

Parametrised per-channel measurement sweep controller: steps the comparator threshold (via the serial DAC) and the delay-line code across a programmed raster, samples the channel comparator on internal strobes at every point and streams one result word per point. Sits between the measure-unit register block (config, start/abort) and the DAC driver / delay line of one channel. It supersedes the fixed-width, delta-only channel controller with full sweep sequencing, selectable mode and a result handshake.

---
 rtl/ch_sweep_pkg.sv | 21 ++
 rtl/ch_sweep_step.sv | 13 +
 rtl/ch_sweep_ctl.sv | 198 +++++++++++++++++++
 tb/tb_ch_sweep_ctl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_sweep_pkg.sv
// Shared types and defaults for the per-channel sweep controller.
package ch_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DAC_WR,
      ST_SETTLE,
      ST_DC_SET,
      ST_SAMPLE,
      ST_REPORT,
      ST_DONE
   } state_t;

   typedef enum logic {
      MODE_RASTER = 1'b0,
      MODE_DELAY  = 1'b1
   } mode_t;

   localparam logic [7:0] DAC_CMD_DEF = 8'h30;

endpackage

// File: rtl/ch_sweep_step.sv
// Width-parametrised step adder; ovf_o flags that the sum left the W-bit range.
module ch_sweep_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   assign {ovf_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/ch_sweep_ctl.sv
// Channel measurement sweep controller: threshold/delay raster, strobe sampling, result stream.
// CH_SWEEP_AVG_EN: when defined each point accumulates 2^AVG_LOG2 strobes, otherwise one.
//
// state     | meaning
// IDLE      | waiting for start_i
// DAC_WR    | issue threshold write once the DAC driver is idle
// SETTLE    | wait settle time and DAC idle
// DC_SET    | delay code applied, strobes ignored this cycle
// SAMPLE    | accumulate hits over the required strobes
// REPORT    | present result until accepted, then advance
// DONE      | one-cycle completion pulse
module ch_sweep_ctl
   import ch_sweep_pkg::*;
#(
   parameter int         TH_W       = 16,
   parameter int         DC_W       = 10,
   parameter logic [7:0] DAC_CMD    = DAC_CMD_DEF,
   parameter int         SETTLE_CYC = 64,
   parameter int         AVG_LOG2   = 4
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  mode_i,
   input  logic [TH_W-1:0]       th_start_i,
   input  logic [TH_W-1:0]       th_stop_i,
   input  logic [TH_W-1:0]       th_delta_i,
   input  logic [DC_W-1:0]       dc_delta_i,
   input  logic                  stb_i,
   input  logic                  hit_i,
   output logic [8+TH_W-1:0]     dac_dat_o,
   output logic                  dac_wre_o,
   input  logic                  dac_rdy_i,
   output logic [DC_W-1:0]       d_code_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [TH_W-1:0]       res_th_o,
   output logic [DC_W-1:0]       res_dc_o,
   output logic [AVG_LOG2:0]     res_cnt_o
);

   localparam int CNT_W = AVG_LOG2 + 1;
`ifdef CH_SWEEP_AVG_EN
   localparam int NSTB = 2 ** AVG_LOG2;
`else
   localparam int NSTB = 1;
`endif
   localparam int               SC_W      = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(NSTB - 1);
   localparam logic [SC_W-1:0]  SETTLE_LD = SC_W'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [TH_W-1:0]  th_q, th_d, th_stop_q, th_stop_d, th_dlt_q, th_dlt_d;
   logic [DC_W-1:0]  dc_q, dc_d, dc_dlt_q, dc_dlt_d;
   logic [SC_W-1:0]  set_cnt_q, set_cnt_d;
   logic [CNT_W-1:0] stb_cnt_q, stb_cnt_d, hit_q, hit_d;

   logic [TH_W-1:0]  th_sum;
   logic [DC_W-1:0]  dc_sum;
   logic             th_ovf, dc_ovf;

   ch_sweep_step #(.W(TH_W)) u_th_step (
      .a_i   (th_q),
      .b_i   (th_dlt_q),
      .sum_o (th_sum),
      .ovf_o (th_ovf)
   );

   ch_sweep_step #(.W(DC_W)) u_dc_step (
      .a_i   (dc_q),
      .b_i   (dc_dlt_q),
      .sum_o (dc_sum),
      .ovf_o (dc_ovf)
   );

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_RASTER;
         th_q      <= '0;
         th_stop_q <= '0;
         th_dlt_q  <= '0;
         dc_q      <= '0;
         dc_dlt_q  <= '0;
         set_cnt_q <= '0;
         stb_cnt_q <= '0;
         hit_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         th_q      <= th_d;
         th_stop_q <= th_stop_d;
         th_dlt_q  <= th_dlt_d;
         dc_q      <= dc_d;
         dc_dlt_q  <= dc_dlt_d;
         set_cnt_q <= set_cnt_d;
         stb_cnt_q <= stb_cnt_d;
         hit_q     <= hit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      th_d      = th_q;
      th_stop_d = th_stop_q;
      th_dlt_d  = th_dlt_q;
      dc_d      = dc_q;
      dc_dlt_d  = dc_dlt_q;
      set_cnt_d = set_cnt_q;
      stb_cnt_d = stb_cnt_q;
      hit_d     = hit_q;
      dac_wre_o = 1'b0;
      dac_dat_o = '0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_DAC_WR;
               mode_d    = mode_t'(mode_i);
               th_d      = th_start_i;
               th_stop_d = th_stop_i;
               th_dlt_d  = (th_delta_i == '0) ? TH_W'(1) : th_delta_i;
               dc_dlt_d  = (dc_delta_i == '0) ? DC_W'(1) : dc_delta_i;
               dc_d      = '0;
            end
         end
         ST_DAC_WR: begin
            dc_d      = '0;
            dac_dat_o = {DAC_CMD, th_q};
            if (dac_rdy_i) begin
               dac_wre_o = 1'b1;
               set_cnt_d = SETTLE_LD;
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (set_cnt_q != '0) begin
               set_cnt_d = set_cnt_q - 1'b1;
            end else if (dac_rdy_i) begin
               state_d = ST_DC_SET;
            end
         end
         ST_DC_SET: begin
            stb_cnt_d = STB_LAST;
            hit_d     = '0;
            state_d   = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (stb_i) begin
               hit_d = hit_q + CNT_W'(hit_i);
               if (stb_cnt_q == '0) state_d = ST_REPORT;
               else                 stb_cnt_d = stb_cnt_q - 1'b1;
            end
         end
         ST_REPORT: begin
            if (res_ready_i) begin
               if (!dc_ovf) begin
                  dc_d    = dc_sum;
                  state_d = ST_DC_SET;
               end else begin
                  // Delay row exhausted: step threshold or finish.
                  dc_d = '0;
                  if (mode_q == MODE_DELAY || th_ovf || th_sum > th_stop_q) begin
                     state_d = ST_DONE;
                  end else begin
                     th_d    = th_sum;
                     state_d = ST_DAC_WR;
                  end
               end
            end
         end
         ST_DONE: begin
            dc_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         dc_d    = '0;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign res_valid_o = (state_q == ST_REPORT);
   assign d_code_o    = dc_q;
   assign res_th_o    = th_q;
   assign res_dc_o    = dc_q;
   assign res_cnt_o   = hit_q;

endmodule

// File: tb/tb_ch_sweep_ctl.sv
// Self-checking bench for ch_sweep_ctl: table of sweep configurations plus abort/backpressure sequences.
module tb_ch_sweep_ctl;

   localparam int TH_W       = 16;
   localparam int DC_W       = 10;
   localparam int AVG_LOG2   = 2;
   localparam int SETTLE_CYC = 4;
`ifdef CH_SWEEP_AVG_EN
   localparam int NSTB = 4;
   localparam int PAT_MODE = 2;
`else
   localparam int NSTB = 1;
   localparam int PAT_MODE = 1;
`endif

   logic              clk_i, arst_i, start_i, abort_i, mode_i;
   logic [TH_W-1:0]   th_start_i, th_stop_i, th_delta_i;
   logic [DC_W-1:0]   dc_delta_i;
   logic              stb_i, hit_i, dac_wre_o, dac_rdy_i, busy_o, done_o;
   logic [8+TH_W-1:0] dac_dat_o;
   logic [DC_W-1:0]   d_code_o, res_dc_o;
   logic              res_valid_o, res_ready_i;
   logic [TH_W-1:0]   res_th_o;
   logic [AVG_LOG2:0] res_cnt_o;

   ch_sweep_ctl #(
      .TH_W(TH_W), .DC_W(DC_W), .DAC_CMD(8'h30), .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
      .th_start_i(th_start_i), .th_stop_i(th_stop_i), .th_delta_i(th_delta_i),
      .dc_delta_i(dc_delta_i), .stb_i(stb_i), .hit_i(hit_i), .dac_dat_o(dac_dat_o),
      .dac_wre_o(dac_wre_o), .dac_rdy_i(dac_rdy_i), .d_code_o(d_code_o), .busy_o(busy_o),
      .done_o(done_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_th_o(res_th_o), .res_dc_o(res_dc_o), .res_cnt_o(res_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic            mode;
      logic [TH_W-1:0] ths, thp, thd;
      logic [DC_W-1:0] dcd;
      int              hit_mode;
      int              n_res;
      int              n_dac;
   } vec_t;

   vec_t tbl[8];
   int checks = 0;
   int errors = 0;

   logic [TH_W+DC_W+AVG_LOG2:0] res_q[$], exp_res[$];
   logic [8+TH_W-1:0]           dac_q[$], exp_dac[$];
   int  cyc = 0, n_done = 0, done_cyc = 0, last_acc = 0;
   bit  chk_busy = 0;
   int  hit_mode = 1;
   int  stb_div = 0, stb_idx = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobe source: one pulse every third cycle; hit pattern 1,1,1,0 in pattern mode.
   initial begin
      stb_i = 1'b0;
      hit_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         stb_div = (stb_div + 1) % 3;
         if (stb_div == 0) begin
            stb_i = 1'b1;
            hit_i = (hit_mode == 0) ? 1'b0 : (hit_mode == 1) ? 1'b1 : ((stb_idx % 4) != 3);
            stb_idx++;
         end else begin
            stb_i = 1'b0;
            hit_i = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         cyc++;
         if (chk_busy) begin
            chk_busy = 0;
            chk("busy_after_done", busy_o, 0);
            chk("dcode_after_done", d_code_o, 0);
         end
         if (dac_wre_o) dac_q.push_back(dac_dat_o);
         if (res_valid_o && res_ready_i && !abort_i) begin
            res_q.push_back({res_th_o, res_dc_o, res_cnt_o});
            last_acc = cyc;
         end
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
            chk_busy = 1;
         end
      end
   end

   task automatic build_exp(input vec_t v);
      int th, dc, dd, td, ecnt;
      exp_res.delete();
      exp_dac.delete();
      dd   = (v.dcd == 0) ? 1 : int'(v.dcd);
      td   = (v.thd == 0) ? 1 : int'(v.thd);
      ecnt = (v.hit_mode == 0) ? 0 : (v.hit_mode == 1) ? NSTB : 3;
      th   = int'(v.ths);
      forever begin
         exp_dac.push_back({8'h30, th[15:0]});
         dc = 0;
         forever begin
            exp_res.push_back({th[15:0], dc[9:0], ecnt[2:0]});
            if (dc + dd > 1023) break;
            dc += dd;
         end
         if (v.mode) break;
         if (th + td > int'(v.thp)) break;
         th += td;
      end
   endtask

   task automatic run_sweep(input vec_t v, input int idx, input bit hold);
      string tag;
      logic [TH_W+DC_W+AVG_LOG2:0] cap;
      tag = $sformatf("v%0d", idx);
      build_exp(v);
      hit_mode = v.hit_mode;
      res_q.delete();
      dac_q.delete();
      n_done = 0;
      @(posedge clk_i); #1;
      mode_i = v.mode; th_start_i = v.ths; th_stop_i = v.thp;
      th_delta_i = v.thd; dc_delta_i = v.dcd;
      start_i = 1'b1; res_ready_i = !hold;
      @(posedge clk_i); #1;
      start_i = 1'b0; mode_i = ~v.mode; th_start_i = 16'hA5A5;
      th_stop_i = 16'h0001; th_delta_i = 16'h0003; dc_delta_i = 10'h001;
      @(negedge clk_i);
      chk({tag, "_busy_at1"}, busy_o, 1);
      chk({tag, "_wre_at1"}, dac_wre_o, 1);
      if (hold) begin
         for (int c = 0; c < 200 && !res_valid_o; c++) @(negedge clk_i);
         chk({tag, "_valid_seen"}, res_valid_o, 1);
         cap = {res_th_o, res_dc_o, res_cnt_o};
         for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk({tag, "_hold_stable"}, {res_valid_o, res_th_o, res_dc_o, res_cnt_o}, {1'b1, cap});
         end
         @(posedge clk_i); #1;
         res_ready_i = 1'b1;
      end
      for (int c = 0; c < 40000 && n_done == 0; c++) @(posedge clk_i);
      repeat (5) @(posedge clk_i);
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_done_after_accept"}, done_cyc, last_acc + 1);
      chk({tag, "_n_res"}, res_q.size(), v.n_res);
      chk({tag, "_n_dac"}, dac_q.size(), v.n_dac);
      for (int k = 0; k < exp_res.size(); k++)
         chk($sformatf("%s_res%0d", tag, k), (k < res_q.size()) ? longint'(res_q[k]) : -1, exp_res[k]);
      for (int k = 0; k < exp_dac.size(); k++)
         chk($sformatf("%s_dac%0d", tag, k), (k < dac_q.size()) ? longint'(dac_q[k]) : -1, exp_dac[k]);
   endtask

   initial begin
      arst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
      th_start_i = '0; th_stop_i = '0; th_delta_i = '0; dc_delta_i = '0;
      dac_rdy_i = 1'b1; res_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_dac_dat", dac_dat_o, 0);
      chk("rst_dac_wre", dac_wre_o, 0);
      chk("rst_dcode", d_code_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_valid", res_valid_o, 0);
      chk("rst_res", {res_th_o, res_dc_o, res_cnt_o}, 0);
      @(posedge clk_i); #1;
      arst_i = 1'b0;

      //          mode  ths       thp       thd       dcd     hit        nres  ndac
      tbl[0] = '{1'b1, 16'h0100, 16'h0000, 16'h0000, 10'd256, 1,        4,    1};
      tbl[1] = '{1'b0, 16'h0010, 16'h0030, 16'h0010, 10'd512, 0,        6,    3};
      tbl[2] = '{1'b0, 16'h8000, 16'hFFFF, 16'hFFFF, 10'd512, 1,        2,    1};
      tbl[3] = '{1'b0, 16'h0040, 16'h0020, 16'h0001, 10'd512, 1,        2,    1};
      tbl[4] = '{1'b1, 16'h0007, 16'h0000, 16'h0000, 10'd0,   0,        1024, 1};
      tbl[5] = '{1'b0, 16'h0005, 16'h0006, 16'h0000, 10'h300, 1,        4,    2};
      tbl[6] = '{1'b0, 16'hFFF0, 16'hFFFF, 16'h0008, 10'h3FF, 0,        4,    2};
      tbl[7] = '{1'b1, 16'h0100, 16'h0000, 16'h0000, 10'd256, PAT_MODE, 4,    1};

      for (int i = 0; i < 8; i++) run_sweep(tbl[i], i, 1'b0);

      run_sweep(tbl[0], 8, 1'b1);

      // Abort while SETTLE is held by a busy DAC driver.
      n_done = 0;
      @(posedge clk_i); #1;
      mode_i = 1'b1; th_start_i = 16'h0100; dc_delta_i = 10'd256; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(posedge clk_i); #1;
      dac_rdy_i = 1'b0;
      repeat (8) @(posedge clk_i);
      @(negedge clk_i);
      chk("abort_busy_before", busy_o, 1);
      @(posedge clk_i); #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      @(negedge clk_i);
      chk("abort_busy", busy_o, 0);
      chk("abort_dcode", d_code_o, 0);
      chk("abort_valid", res_valid_o, 0);
      repeat (10) @(posedge clk_i);
      chk("abort_no_done", n_done, 0);
      @(posedge clk_i); #1;
      dac_rdy_i = 1'b1;

      // Abort and accept in the same cycle: abort must win.
      @(posedge clk_i); #1;
      res_ready_i = 1'b0; hit_mode = 1;
      mode_i = 1'b1; th_start_i = 16'h0100; dc_delta_i = 10'd256; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 0; c < 200 && !res_valid_o; c++) @(negedge clk_i);
      chk("abrdy_valid_seen", res_valid_o, 1);
      @(posedge clk_i); #1;
      abort_i = 1'b1; res_ready_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      @(negedge clk_i);
      chk("abrdy_busy", busy_o, 0);
      chk("abrdy_valid", res_valid_o, 0);
      chk("abrdy_dcode", d_code_o, 0);
      repeat (5) @(posedge clk_i);
      chk("abrdy_no_done", n_done, 0);

      run_sweep(tbl[1], 9, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
